// File: rtl/poly_op_sequencer.sv
// Issue/drain sequencer for coefficient-wise MULT/MAC/ADD/SUB over LANES-wide BRAM words.
// Define POLY_OP_PERF_CNT_EN to add the cyc_cnt_o / stall_cnt_o performance counters.
//
// state | meaning
// IDLE  | waiting for start; an illegal-mode start reports done one cycle later
// ISSUE | one read per unstalled cycle until DEPTH words are issued
// DRAIN | waiting for every issued word to be written back
module poly_op_sequencer #(
  parameter int LANES    = 4,
  parameter int ADDR_W   = 6,
  parameter int DEPTH    = 64,
  parameter int RD_LAT   = 1,
  parameter int PIPE_LAT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        mode_i,
  input  logic [ADDR_W-1:0] base_a_i,
  input  logic [ADDR_W-1:0] base_b_i,
  input  logic [ADDR_W-1:0] base_c_i,
  input  logic              stall_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_a_o,
  output logic [ADDR_W-1:0] rd_addr_b_o,
  output logic [ADDR_W-1:0] rd_addr_c_o,
  output logic              dp_valid_i,
  output logic [1:0]        dp_op_o,
  output logic [LANES-1:0]  dp_lanes_o,
  input  logic              dp_valid_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o
`ifdef POLY_OP_PERF_CNT_EN
  ,
  output logic [15:0]       cyc_cnt_o,
  output logic [15:0]       stall_cnt_o
`endif
);

  localparam int WR_LAT = RD_LAT + PIPE_LAT;
  localparam int FL_W   = $clog2(WR_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [1:0] OP_MAC = 2'd1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [1:0]          mode_q;
  logic [ADDR_W-1:0]   base_a_q, base_b_q, base_c_q;
  logic                busy_q, done_q, err_q, bad_pend_q;
  logic                rd_en_q;
  logic [ADDR_W-1:0]   rd_addr_a_q, rd_addr_b_q, rd_addr_c_q;
  logic [ADDR_W-1:0]   wr_head_q;
  logic [FL_W-1:0]     fl_q;
  logic [FL_W-1:0]     fl_d;
  logic                start_ok;
  logic                mismatch;

  logic [RD_LAT-1:0]               dv_q;
  logic [WR_LAT-1:0]               wv_q;
  logic [WR_LAT-1:0][ADDR_W-1:0]   wa_q;

  assign start_ok = (state_q == IDLE) && !bad_pend_q && start_i && !mode_i[2];
  assign mismatch = dp_valid_o ^ wv_q[WR_LAT-1];
  // In-flight words: issued reads not yet written back, including this cycle's strobes.
  assign fl_d = fl_q + FL_W'(rd_en_q) - FL_W'(wv_q[WR_LAT-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      mode_q      <= '0;
      base_a_q    <= '0;
      base_b_q    <= '0;
      base_c_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      bad_pend_q  <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      rd_addr_c_q <= '0;
      wr_head_q   <= '0;
      fl_q        <= '0;
    end else begin
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      bad_pend_q <= 1'b0;
      fl_q       <= fl_d;
      if (mismatch) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (bad_pend_q) begin
            done_q <= 1'b1;
          end else if (start_i) begin
            if (!mode_i[2]) begin
              state_q  <= ISSUE;
              busy_q   <= 1'b1;
              err_q    <= 1'b0;
              mode_q   <= mode_i[1:0];
              base_a_q <= base_a_i;
              base_b_q <= base_b_i;
              base_c_q <= base_c_i;
              idx_q    <= '0;
            end else begin
              err_q      <= 1'b1;
              bad_pend_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (!stall_i) begin
            rd_en_q     <= 1'b1;
            rd_addr_a_q <= base_a_q + idx_q;
            rd_addr_b_q <= base_b_q + idx_q;
            rd_addr_c_q <= (mode_q == OP_MAC) ? base_c_q + idx_q : '0;
            wr_head_q   <= base_c_q + idx_q;
            idx_q       <= idx_q + ADDR_W'(1);
            if (idx_q == LAST_IDX) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (fl_d == '0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath is non-stallable, so valid and write address simply ride fixed-length shift lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      dv_q <= '0;
      wv_q <= '0;
      wa_q <= '0;
    end else begin
      dv_q[0] <= rd_en_q;
      for (int k = 1; k < RD_LAT; k++) dv_q[k] <= dv_q[k-1];
      wv_q[0] <= rd_en_q;
      wa_q[0] <= wr_head_q;
      for (int k = 1; k < WR_LAT; k++) begin
        wv_q[k] <= wv_q[k-1];
        wa_q[k] <= wa_q[k-1];
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rd_en_o     = rd_en_q;
  assign rd_addr_a_o = rd_addr_a_q;
  assign rd_addr_b_o = rd_addr_b_q;
  assign rd_addr_c_o = rd_addr_c_q;
  assign dp_valid_i  = dv_q[RD_LAT-1];
  assign dp_op_o     = mode_q;
  assign dp_lanes_o  = {LANES{dv_q[RD_LAT-1]}};
  assign wr_en_o     = wv_q[WR_LAT-1];
  assign wr_addr_o   = wa_q[WR_LAT-1];

`ifdef POLY_OP_PERF_CNT_EN
  logic [15:0] cyc_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if (start_ok) begin
      cyc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (busy_q && cyc_cnt_q != 16'hFFFF) cyc_cnt_q <= cyc_cnt_q + 16'd1;
      if (state_q == ISSUE && stall_i && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign cyc_cnt_o   = cyc_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_poly_op_sequencer.sv
// Directed bench: DEPTH=64 and DEPTH=8 sequencers share stimulus; a per-operation
// timeline model built from the issue/latency rules predicts every output each cycle.
`timescale 1ns/1ps
module tb_poly_op_sequencer;
  localparam int AW   = 6;
  localparam int WL   = 9;
  localparam int MAXC = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stall = 1'b0;
  logic [2:0] mode = '0;
  logic [AW-1:0] ba = '0, bb = '0, bc = '0;

  logic busy [2];
  logic done [2];
  logic err [2];
  logic rd_en [2];
  logic dvi [2];
  logic dvo [2];
  logic wr_en [2];
  logic [AW-1:0] ra [2];
  logic [AW-1:0] rb [2];
  logic [AW-1:0] rc [2];
  logic [AW-1:0] wa [2];
  logic [1:0] op [2];
  logic [3:0] lanes [2];
`ifdef POLY_OP_PERF_CNT_EN
  logic [15:0] ccnt [2];
  logic [15:0] scnt [2];
`endif

  int cyc = 0;
  int base = 0;
  bit win_on = 1'b0;
  int drop_cyc [2] = '{-1, -1};

  int checks = 0;
  int errors = 0;

  // Expected timelines, indexed by cycle relative to the start edge.
  bit e_rd [2][MAXC];
  bit e_dvi [2][MAXC];
  bit e_wr [2][MAXC];
  bit e_busy [2][MAXC];
  bit e_done [2][MAXC];
  bit e_err [2][MAXC];
  bit e_zero [2][MAXC];
  int e_ra [2][MAXC];
  int e_rb [2][MAXC];
  int e_rc [2][MAXC];
  int e_wa [2][MAXC];
  int e_cyc [2];
  int e_stall [2];
  int e_done_at [2];
  bit e_mac;
  int e_op;

  int done_at [2];
  int rdc [2];
  int wrc [2];
  int max_fl [2];
  int seq_ra [8];
  int seq_wa [8];
  int nra, nwa;
  int r;

  int lit_ra [8] = '{60, 61, 62, 63, 0, 1, 2, 3};
  int lit_wa [8] = '{62, 63, 0, 1, 2, 3, 4, 5};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    poly_op_sequencer #(
      .LANES(4), .ADDR_W(AW), .DEPTH(g == 0 ? 64 : 8), .RD_LAT(1), .PIPE_LAT(8)
    ) u_dut (
      .clk(clk), .rst(rst), .start_i(start), .mode_i(mode),
      .base_a_i(ba), .base_b_i(bb), .base_c_i(bc), .stall_i(stall),
      .busy_o(busy[g]), .done_o(done[g]), .err_o(err[g]), .rd_en_o(rd_en[g]),
      .rd_addr_a_o(ra[g]), .rd_addr_b_o(rb[g]), .rd_addr_c_o(rc[g]),
      .dp_valid_i(dvi[g]), .dp_op_o(op[g]), .dp_lanes_o(lanes[g]),
      .dp_valid_o(dvo[g]), .wr_en_o(wr_en[g]), .wr_addr_o(wa[g])
`ifdef POLY_OP_PERF_CNT_EN
      , .cyc_cnt_o(ccnt[g]), .stall_cnt_o(scnt[g])
`endif
    );
    // Datapath loopback; optionally loses one output valid.
    assign dvo[g] = wr_en[g] & ~(win_on && ((cyc - base) == drop_cyc[g]));
  end

  task automatic chk(input string nm, input int i, input int rel, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d rel=%0d got=%0d exp=%0d", nm, i, rel, act, exp);
    end
  endtask

  task automatic build(input int i, input int d, input logic [2:0] m, input int a0, input int b0,
                       input int c0, input int slo, input int shi, input int drop_w, input int rst_at);
    int k, c, last;
    for (int t = 0; t < MAXC; t++) begin
      e_rd[i][t] = 0; e_dvi[i][t] = 0; e_wr[i][t] = 0; e_busy[i][t] = 0;
      e_done[i][t] = 0; e_err[i][t] = 0; e_zero[i][t] = 0;
      e_ra[i][t] = 0; e_rb[i][t] = 0; e_rc[i][t] = 0; e_wa[i][t] = 0;
    end
    drop_cyc[i] = -1;
    e_stall[i] = 0;
    e_cyc[i] = 0;
    if (m > 3'd3) begin
      for (int t = 0; t < MAXC; t++) e_err[i][t] = 1;
      e_done[i][1] = 1;
    end else begin
      k = 0;
      c = 1;
      while (k < d) begin
        if ((c - 1) >= slo && (c - 1) <= shi) begin
          e_stall[i]++;
        end else begin
          e_rd[i][c] = 1;
          e_ra[i][c] = (a0 + k) % 64;
          e_rb[i][c] = (b0 + k) % 64;
          e_rc[i][c] = (c0 + k) % 64;
          e_dvi[i][c+1] = 1;
          e_wr[i][c+WL] = 1;
          e_wa[i][c+WL] = (c0 + k) % 64;
          if (k == drop_w) drop_cyc[i] = c + WL;
          k++;
        end
        c++;
      end
      last = (c - 1) + WL;
      e_done[i][last+1] = 1;
      for (int t = 0; t <= last; t++) e_busy[i][t] = 1;
      if (drop_cyc[i] >= 0)
        for (int t = drop_cyc[i] + 1; t < MAXC; t++) e_err[i][t] = 1;
      e_cyc[i] = last + 1;
    end
    if (rst_at >= 0) begin
      for (int t = rst_at + 1; t < MAXC; t++) begin
        e_rd[i][t] = 0; e_dvi[i][t] = 0; e_wr[i][t] = 0; e_busy[i][t] = 0;
        e_done[i][t] = 0; e_err[i][t] = 0; e_zero[i][t] = 1;
      end
    end
    e_done_at[i] = -1;
    for (int t = MAXC - 1; t >= 0; t--) if (e_done[i][t]) e_done_at[i] = t;
  endtask

  // Compare process: every output of both instances, every cycle of an operation window.
  always @(negedge clk) begin
    if (win_on) begin
      r = cyc - base;
      for (int i = 0; i < 2; i++) begin
        if (r == 0) begin
          done_at[i] = -1; rdc[i] = 0; wrc[i] = 0; max_fl[i] = 0;
          if (i == 1) begin nra = 0; nwa = 0; end
        end
        chk("busy", i, r, busy[i], e_busy[i][r]);
        chk("done", i, r, done[i], e_done[i][r]);
        chk("err", i, r, err[i], e_err[i][r]);
        chk("rd_en", i, r, rd_en[i], e_rd[i][r]);
        chk("dp_valid_i", i, r, dvi[i], e_dvi[i][r]);
        chk("dp_lanes", i, r, lanes[i], e_dvi[i][r] ? 15 : 0);
        chk("wr_en", i, r, wr_en[i], e_wr[i][r]);
        if (e_rd[i][r]) begin
          chk("rd_addr_a", i, r, ra[i], e_ra[i][r]);
          chk("rd_addr_b", i, r, rb[i], e_rb[i][r]);
          if (e_mac) chk("rd_addr_c", i, r, rc[i], e_rc[i][r]);
        end
        if (e_wr[i][r]) chk("wr_addr", i, r, wa[i], e_wa[i][r]);
        if (e_busy[i][r]) chk("dp_op", i, r, op[i], e_op);
        if (e_zero[i][r]) begin
          chk("rst_addr_a", i, r, ra[i], 0);
          chk("rst_addr_b", i, r, rb[i], 0);
          chk("rst_addr_c", i, r, rc[i], 0);
          chk("rst_wr_addr", i, r, wa[i], 0);
          chk("rst_dp_op", i, r, op[i], 0);
        end
        if (done[i] && done_at[i] < 0) done_at[i] = r;
        if (rd_en[i]) rdc[i]++;
        if (wr_en[i]) wrc[i]++;
        if (rdc[i] - wrc[i] > max_fl[i]) max_fl[i] = rdc[i] - wrc[i];
        if (i == 1 && rd_en[1] && nra < 8) begin seq_ra[nra] = int'(ra[1]); nra++; end
        if (i == 1 && wr_en[1] && nwa < 8) begin seq_wa[nwa] = int'(wa[1]); nwa++; end
      end
    end
  end

  task automatic run_op(input logic [2:0] m, input int a0, input int b0, input int c0,
                        input int slo, input int shi, input int drop_w, input int rst_at);
    int len;
    build(0, 64, m, a0, b0, c0, slo, shi, drop_w, rst_at);
    build(1, 8, m, a0, b0, c0, slo, shi, drop_w, rst_at);
    e_mac = (m == 3'd1);
    e_op = int'(m[1:0]);
    len = (e_done_at[0] > e_done_at[1] ? e_done_at[0] : e_done_at[1]) + 4;
    if (rst_at >= 0) len = rst_at + 6;
    @(posedge clk); #1;
    start = 1'b1; mode = m; ba = AW'(a0); bb = AW'(b0); bc = AW'(c0);
    @(posedge clk); #1;
    start = 1'b0;
    base = cyc;
    win_on = 1'b1;
    for (int c = 0; c < len; c++) begin
      stall = (c >= slo && c <= shi);
      rst = (c == rst_at);
      @(posedge clk); #1;
    end
    win_on = 1'b0;
    stall = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_busy", i, -1, busy[i], 0);
      chk("reset_done", i, -1, done[i], 0);
      chk("reset_err", i, -1, err[i], 0);
      chk("reset_rd_en", i, -1, rd_en[i], 0);
      chk("reset_dp_valid_i", i, -1, dvi[i], 0);
      chk("reset_wr_en", i, -1, wr_en[i], 0);
      chk("reset_wr_addr", i, -1, wa[i], 0);
      chk("reset_lanes", i, -1, lanes[i], 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // MULT, bases 0, no stall
    run_op(3'd0, 0, 0, 0, -1, -1, -1, -1);
    chk("mult_done_cycle", 0, -1, done_at[0], 74);
    chk("mult_done_cycle", 1, -1, done_at[1], 18);
    chk("mult_err_end", 0, -1, err[0], 0);

    // ADD with wrapping bases
    run_op(3'd2, 60, 3, 62, -1, -1, -1, -1);
    chk("add_done_cycle", 1, -1, done_at[1], 18);
    chk("add_done_cycle", 0, -1, done_at[0], 74);
    for (int j = 0; j < 8; j++) begin
      chk("add_rd_addr_a_seq", 1, j, seq_ra[j], lit_ra[j]);
      chk("add_wr_addr_seq", 1, j, seq_wa[j], lit_wa[j]);
    end

    // MAC with stall in cycles 5..9
    run_op(3'd1, 0, 0, 0, 5, 9, -1, -1);
    chk("mac_done_cycle", 0, -1, done_at[0], 79);
    chk("mac_inflight_le9", 0, -1, (max_fl[0] <= 9), 1);
    chk("mac_rd_count", 0, -1, rdc[0], 64);
`ifdef POLY_OP_PERF_CNT_EN
    chk("mac_stall_cnt", 0, -1, scnt[0], 5);
    chk("mac_cyc_cnt", 0, -1, ccnt[0], 79);
    chk("mac_stall_cnt", 1, -1, scnt[1], e_stall[1]);
    chk("mac_cyc_cnt", 1, -1, ccnt[1], e_cyc[1]);
`endif

    // MULT with one dropped datapath valid at write 20
    run_op(3'd0, 0, 0, 0, -1, -1, 20, -1);
    chk("drop_done_cycle", 0, -1, done_at[0], 74);
    chk("drop_err_sticky", 0, -1, err[0], 1);
    chk("drop_err_clean", 1, -1, err[1], 0);

    // SUB clears the previous error
    run_op(3'd3, 10, 20, 30, -1, -1, -1, -1);
    chk("sub_err_cleared", 0, -1, err[0], 0);
    chk("sub_done_cycle", 0, -1, done_at[0], 74);

    // Illegal mode
    run_op(3'd5, 0, 0, 0, -1, -1, -1, -1);
    chk("illegal_done_cycle", 0, -1, done_at[0], 1);
    chk("illegal_rd_count", 0, -1, rdc[0], 0);
    chk("illegal_err", 0, -1, err[0], 1);

    // Reset at cycle 30 of a MULT
    run_op(3'd0, 0, 0, 0, -1, -1, -1, 30);
    chk("rst_no_done", 0, -1, done_at[0], -1);
    chk("rst_wr_count", 0, -1, wrc[0], 21);

    // Clean run after the abort
    run_op(3'd0, 5, 6, 7, -1, -1, -1, -1);
    chk("post_rst_done_cycle", 0, -1, done_at[0], 74);
    chk("post_rst_err", 0, -1, err[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
